// File: rtl/jtag_pkg.sv
// ============================================================================
// Module  : jtag_pkg
// Brief   : TAP state codes shared with the TAP controller, and instruction codes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package jtag_pkg;

    typedef enum logic [4:0] {
        TAP_TEST_LOGIC_RESET = 5'd0,
        TAP_RUN_TEST_IDLE    = 5'd1,
        TAP_SELECT_DR        = 5'd2,
        TAP_CAPTURE_DR       = 5'd3,
        TAP_SHIFT_DR         = 5'd4,
        TAP_EXIT1_DR         = 5'd5,
        TAP_PAUSE_DR         = 5'd6,
        TAP_EXIT2_DR         = 5'd7,
        TAP_UPDATE_DR        = 5'd8,
        TAP_SELECT_IR        = 5'd9,
        TAP_CAPTURE_IR       = 5'd10,
        TAP_SHIFT_IR         = 5'd11,
        TAP_EXIT1_IR         = 5'd12,
        TAP_PAUSE_IR         = 5'd13,
        TAP_EXIT2_IR         = 5'd14,
        TAP_UPDATE_IR        = 5'd15
    } tap_state_t;

    localparam logic [3:0] c_INSTR_ABORT  = 4'b1000;
    localparam logic [3:0] c_INSTR_USER   = 4'b0100;
    localparam logic [3:0] c_INSTR_IDCODE = 4'b1110;
    localparam logic [3:0] c_INSTR_BYPASS = 4'b1111;

    // Mandatory IR capture LSBs; upper bits are zero.
    localparam logic [1:0] c_IR_CAPTURE_LSB = 2'b01;

endpackage

`default_nettype wire

// File: rtl/jtag_dr_shifter.sv
// ============================================================================
// Module  : jtag_dr_shifter
// Brief   : Generic data-register shifter: parallel capture, LSB-first shift.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_dr_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_capture,
    input  logic [WIDTH-1:0] i_capture_val,
    input  logic             i_shift,
    input  logic             i_tdi,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_capture) begin
            r_q <= i_capture_val;
        end else if (i_shift) begin
            r_q <= {i_tdi, r_q[WIDTH-1:1]};
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/jtag_shift_chain.sv
// ============================================================================
// Module  : jtag_shift_chain
// Brief   : JTAG IR/DR shift path (IR, IDCODE, BYPASS, optional USER register).
//           Optional USER DR enabled by defining JTAG_USER_DR_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_shift_chain
    import jtag_pkg::*;
#(
    parameter int          IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'hFAF01,
    parameter int          USER_W     = 8
) (
    input  logic            tck,
    input  logic            reset,
    input  logic            enable,
    input  logic [4:0]      tap_state,
    input  logic            tdi,
`ifdef JTAG_USER_DR_EN
    output logic [USER_W-1:0] user_dr,
    output logic            user_upd,
`endif
    output logic            tdo,
    output logic            tdo_en,
    output logic [IR_W-1:0] ir_value,
    output logic            ir_upd,
    output logic            abort_pulse
);

    localparam logic [IR_W-1:0] c_ir_idcode  = IR_W'(c_INSTR_IDCODE);
    localparam logic [IR_W-1:0] c_ir_abort   = IR_W'(c_INSTR_ABORT);
    localparam logic [IR_W-1:0] c_ir_capture = IR_W'(c_IR_CAPTURE_LSB);

    logic [IR_W-1:0] r_ir_value;
    logic [IR_W-1:0] r_ir_shift;
    logic            r_bypass;
    logic            r_ir_upd;
    logic            r_abort_pulse;

    logic            w_sel_idcode;
    logic            w_sel_bypass;
    logic            w_sel_abort;
    logic            w_cap_dr;
    logic            w_shift_dr;
    logic [31:0]     w_idcode_q;

    assign w_cap_dr     = enable && (tap_state == TAP_CAPTURE_DR);
    assign w_shift_dr   = enable && (tap_state == TAP_SHIFT_DR);
    assign w_sel_idcode = (r_ir_value == c_ir_idcode);
    assign w_sel_abort  = (r_ir_value == c_ir_abort);

    jtag_dr_shifter #(.WIDTH(32)) u_idcode_dr (
        .clk           (tck),
        .rst           (reset),
        .i_capture     (w_cap_dr && w_sel_idcode),
        .i_capture_val (IDCODE_VAL),
        .i_shift       (w_shift_dr && w_sel_idcode),
        .i_tdi         (tdi),
        .o_q           (w_idcode_q)
    );

`ifdef JTAG_USER_DR_EN
    logic              w_sel_user;
    logic [USER_W-1:0] w_user_q;
    logic [USER_W-1:0] r_user_dr;
    logic              r_user_upd;

    assign w_sel_user   = (r_ir_value == IR_W'(c_INSTR_USER));
    assign w_sel_bypass = !w_sel_idcode && !w_sel_user;

    jtag_dr_shifter #(.WIDTH(USER_W)) u_user_dr (
        .clk           (tck),
        .rst           (reset),
        .i_capture     (w_cap_dr && w_sel_user),
        .i_capture_val (r_user_dr),
        .i_shift       (w_shift_dr && w_sel_user),
        .i_tdi         (tdi),
        .o_q           (w_user_q)
    );

    always_ff @(posedge tck) begin
        if (reset) begin
            r_user_dr  <= '0;
            r_user_upd <= 1'b0;
        end else begin
            r_user_upd <= 1'b0;
            if (enable && (tap_state == TAP_UPDATE_DR) && w_sel_user) begin
                r_user_dr  <= w_user_q;
                r_user_upd <= 1'b1;
            end
        end
    end

    assign user_dr  = r_user_dr;
    assign user_upd = r_user_upd;
`else
    // Width kept for a uniform parameter list across builds.
    localparam int c_user_w_unused = USER_W;
    assign w_sel_bypass = !w_sel_idcode;
`endif

    // Pulses default low every edge, so a disabled edge also clears them.
    always_ff @(posedge tck) begin
        if (reset) begin
            r_ir_value    <= c_ir_idcode;
            r_ir_shift    <= '0;
            r_bypass      <= 1'b0;
            r_ir_upd      <= 1'b0;
            r_abort_pulse <= 1'b0;
        end else begin
            r_ir_upd      <= 1'b0;
            r_abort_pulse <= 1'b0;
            if (enable) begin
                case (tap_state)
                    TAP_TEST_LOGIC_RESET: r_ir_value <= c_ir_idcode;
                    TAP_CAPTURE_IR:       r_ir_shift <= c_ir_capture;
                    TAP_SHIFT_IR:         r_ir_shift <= {tdi, r_ir_shift[IR_W-1:1]};
                    TAP_UPDATE_IR: begin
                        r_ir_value <= r_ir_shift;
                        r_ir_upd   <= 1'b1;
                    end
                    TAP_CAPTURE_DR: if (w_sel_bypass) r_bypass <= 1'b0;
                    TAP_SHIFT_DR:   if (w_sel_bypass) r_bypass <= tdi;
                    TAP_UPDATE_DR:  if (w_sel_abort) r_abort_pulse <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        tdo = 1'b0;
        case (tap_state)
            TAP_SHIFT_IR: tdo = r_ir_shift[0];
            TAP_SHIFT_DR: begin
                if (w_sel_idcode)
                    tdo = w_idcode_q[0];
`ifdef JTAG_USER_DR_EN
                else if (w_sel_user)
                    tdo = w_user_q[0];
`endif
                else
                    tdo = r_bypass;
            end
            default: tdo = 1'b0;
        endcase
    end

    logic [30:0] w_idcode_hi_unused;
    assign w_idcode_hi_unused = w_idcode_q[31:1];

    assign tdo_en      = (tap_state == TAP_SHIFT_IR) || (tap_state == TAP_SHIFT_DR);
    assign ir_value    = r_ir_value;
    assign ir_upd      = r_ir_upd;
    assign abort_pulse = r_abort_pulse;

endmodule

`default_nettype wire

// File: tb/tb_jtag_shift_chain.sv
// ============================================================================
// Module  : tb_jtag_shift_chain
// Brief   : Directed self-checking bench for jtag_shift_chain (USER DR steps
//           run only when JTAG_USER_DR_EN is defined).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtag_shift_chain;
    import jtag_pkg::*;

    logic       tck = 1'b0;
    logic       reset;
    logic       enable;
    logic [4:0] tap_state;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] ir_value;
    logic       ir_upd;
    logic       abort_pulse;
`ifdef JTAG_USER_DR_EN
    logic [7:0] user_dr;
    logic       user_upd;
`endif

    int n_checks = 0;
    int n_errors = 0;

    jtag_shift_chain #(
        .IR_W       (4),
        .IDCODE_VAL (32'hFAF01),
        .USER_W     (8)
    ) dut (
        .tck         (tck),
        .reset       (reset),
        .enable      (enable),
        .tap_state   (tap_state),
        .tdi         (tdi),
`ifdef JTAG_USER_DR_EN
        .user_dr     (user_dr),
        .user_upd    (user_upd),
`endif
        .tdo         (tdo),
        .tdo_en      (tdo_en),
        .ir_value    (ir_value),
        .ir_upd      (ir_upd),
        .abort_pulse (abort_pulse)
    );

    always #5 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] st, input logic d);
        tap_state = st;
        tdi       = d;
        #1;
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic step(input logic [4:0] st, input logic d);
        drive(st, d);
        tick();
    endtask

    task automatic load_ir(input logic [3:0] v);
        step(TAP_CAPTURE_IR, 1'b0);
        for (int i = 0; i < 4; i++) step(TAP_SHIFT_IR, v[i]);
        step(TAP_EXIT1_IR, 1'b0);
        step(TAP_UPDATE_IR, 1'b0);
        step(TAP_RUN_TEST_IDLE, 1'b0);
    endtask

    initial begin
        logic [31:0] idv;
        logic [31:0] wv;
        logic [3:0]  byp_in;
        logic [3:0]  byp_out;
        logic [7:0]  uv;
        idv     = 32'hFAF01;
        wv      = 32'h12345678;
        byp_in  = 4'b1101;
        byp_out = 4'b1010;
        uv      = 8'hA5;

        // Reset state
        reset = 1'b1; enable = 1'b1;
        drive(TAP_RUN_TEST_IDLE, 1'b0);
        tick(); tick();
        chk("rst_ir_value", ir_value, 4'hE);
        chk("rst_ir_upd", ir_upd, 1'b0);
        chk("rst_abort", abort_pulse, 1'b0);
        chk("rst_tdo", tdo, 1'b0);
        chk("rst_tdo_en", tdo_en, 1'b0);
        reset = 1'b0;

        // 1: IDCODE serialises LSB first
        step(TAP_CAPTURE_DR, 1'b0);
        for (int i = 0; i < 32; i++) begin
            drive(TAP_SHIFT_DR, 1'b0);
            chk("idcode_tdo", tdo, idv[i]);
            if (i == 0) chk("shift_dr_tdo_en", tdo_en, 1'b1);
            tick();
        end
        step(TAP_EXIT1_DR, 1'b0);
        step(TAP_UPDATE_DR, 1'b0);
        chk("idcode_update_no_abort", abort_pulse, 1'b0);
        step(TAP_RUN_TEST_IDLE, 1'b0);

        // 2: IR capture pattern and update
        step(TAP_CAPTURE_IR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(TAP_SHIFT_IR, 1'b1);
            chk("ir_tdo", tdo, (i == 0) ? 1'b1 : 1'b0);
            if (i == 0) chk("shift_ir_tdo_en", tdo_en, 1'b1);
            tick();
        end
        step(TAP_EXIT1_IR, 1'b0);
        chk("ir_pre_update", ir_value, 4'hE);
        step(TAP_UPDATE_IR, 1'b0);
        chk("ir_updated", ir_value, 4'hF);
        chk("ir_upd_pulse", ir_upd, 1'b1);
        step(TAP_RUN_TEST_IDLE, 1'b0);
        chk("ir_upd_one_cycle", ir_upd, 1'b0);

        // 3: BYPASS one-cycle delay
        step(TAP_CAPTURE_DR, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(TAP_SHIFT_DR, byp_in[i]);
            chk("bypass_tdo", tdo, byp_out[i]);
            tick();
        end
        step(TAP_RUN_TEST_IDLE, 1'b0);

        // Undefined state code holds and drives tdo low
        drive(5'd20, 1'b1);
        chk("undef_tdo", tdo, 1'b0);
        chk("undef_tdo_en", tdo_en, 1'b0);
        tick();
        chk("undef_hold_ir", ir_value, 4'hF);

        // 4: ABORT pulse only with ABORT selected
        load_ir(4'b1000);
        chk("abort_loaded", ir_value, 4'h8);
        step(TAP_CAPTURE_DR, 1'b0);
        step(TAP_SHIFT_DR, 1'b0);
        step(TAP_EXIT1_DR, 1'b0);
        chk("abort_pre", abort_pulse, 1'b0);
        step(TAP_UPDATE_DR, 1'b0);
        chk("abort_pulse", abort_pulse, 1'b1);
        chk("abort_no_ir_upd", ir_upd, 1'b0);
        step(TAP_RUN_TEST_IDLE, 1'b0);
        chk("abort_one_cycle", abort_pulse, 1'b0);

        // enable=0 blocks Update-IR and its pulse
        step(TAP_CAPTURE_IR, 1'b0);
        for (int i = 0; i < 4; i++) step(TAP_SHIFT_IR, 1'b1);
        enable = 1'b0;
        step(TAP_UPDATE_IR, 1'b0);
        chk("dis_no_ir_upd", ir_upd, 1'b0);
        chk("dis_ir_hold", ir_value, 4'h8);
        enable = 1'b1;
        step(TAP_UPDATE_IR, 1'b0);
        chk("en_ir_update", ir_value, 4'hF);
        step(TAP_TEST_LOGIC_RESET, 1'b0);
        chk("tlr_ir_idcode", ir_value, 4'hE);

        step(TAP_CAPTURE_DR, 1'b0);
        step(TAP_UPDATE_DR, 1'b0);
        chk("idcode_no_abort", abort_pulse, 1'b0);
        step(TAP_RUN_TEST_IDLE, 1'b0);

        // 5: freeze mid Shift-DR, then resume
        step(TAP_CAPTURE_DR, 1'b0);
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin
                enable = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    drive(TAP_SHIFT_DR, ~wv[i]);
                    chk("frozen_tdo", tdo, idv[i]);
                    tick();
                end
                enable = 1'b1;
            end
            drive(TAP_SHIFT_DR, wv[i]);
            chk("resume_tdo", tdo, idv[i]);
            tick();
        end
        step(TAP_PAUSE_DR, 1'b0);
        step(TAP_EXIT2_DR, 1'b0);
        for (int i = 0; i < 32; i++) begin
            drive(TAP_SHIFT_DR, 1'b0);
            chk("shifted_word_tdo", tdo, wv[i]);
            tick();
        end
        step(TAP_RUN_TEST_IDLE, 1'b0);

`ifdef JTAG_USER_DR_EN
        // 6: USER register write and readback
        load_ir(4'b0100);
        step(TAP_CAPTURE_DR, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(TAP_SHIFT_DR, uv[i]);
            chk("user_first_tdo", tdo, 1'b0);
            tick();
        end
        step(TAP_EXIT1_DR, 1'b0);
        step(TAP_UPDATE_DR, 1'b0);
        chk("user_dr", user_dr, 8'hA5);
        chk("user_upd_pulse", user_upd, 1'b1);
        chk("user_no_abort", abort_pulse, 1'b0);
        step(TAP_RUN_TEST_IDLE, 1'b0);
        chk("user_upd_one_cycle", user_upd, 1'b0);
        step(TAP_CAPTURE_DR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(TAP_SHIFT_DR, 1'b0);
            chk("user_readback_tdo", tdo, uv[i]);
            tick();
        end
        reset = 1'b1;
        tick();
        chk("midshift_rst_ir", ir_value, 4'hE);
        chk("midshift_rst_user", user_dr, 8'h00);
        reset = 1'b0;
`else
        // USER code behaves as BYPASS when the USER DR is not built
        load_ir(4'b0100);
        chk("user_code_loaded", ir_value, 4'h4);
        step(TAP_CAPTURE_DR, 1'b0);
        drive(TAP_SHIFT_DR, 1'b1);
        chk("user_as_bypass_tdo0", tdo, 1'b0);
        tick();
        drive(TAP_SHIFT_DR, 1'b0);
        chk("user_as_bypass_tdo1", tdo, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        chk("midshift_rst_ir", ir_value, 4'hE);
        reset = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
